// File: rtl/rcc_osc_pkg.sv
// Shared types for the oscillator request responder: FSM state encoding and
// the helper that sizes the shared state counter.
package rcc_osc_pkg;

    typedef enum logic [2:0] {
        OFF,
        WAIT_RDY,
        STABILIZE,
        ON,
        HOLD,
        STOPPING
    } osc_state_e;

    // Wide enough to hold the largest terminal count of any state.
    function automatic int osc_cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rcc_sync_cell.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module rcc_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ker_osc_req_responder.sv
// Oscillator-side responder: merges software and peripheral kernel-clock requests,
// sequences osc_en / ready / stabilisation and returns osc_rdy plus per-requester acks.
//
// state     | meaning
// OFF       | oscillator disabled, waiting for a request
// WAIT_RDY  | osc_en high, waiting for synchronised analog ready (bounded by timeout)
// STABILIZE | ready seen, counting stabilisation cycles before osc_rdy
// ON        | clock stable, osc_rdy high, acks follow requests
// HOLD      | no request, osc_rdy kept high during the hysteresis window
// STOPPING  | osc_en low, waiting for analog ready to fall before OFF
module ker_osc_req_responder
    import rcc_osc_pkg::*;
#(
    parameter int REQ_NUM        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STARTUP_CYCLES = 16,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit RESET_ON       = 1'b0
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic               sw_osc_on,
    input  logic [REQ_NUM-1:0] per_ker_clk_req,
    input  logic               stop_mode,
    input  logic               ker_on_in_stop,
    input  logic               osc_rdy_raw,
    input  logic               fail_clr,
    output logic               osc_en,
    output logic               osc_rdy,
    output logic [REQ_NUM-1:0] ker_clk_ack,
    output logic               osc_fail
);

    localparam int CW = osc_cnt_width(TIMEOUT_CYCLES, STARTUP_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam osc_state_e    RESET_STATE  = RESET_ON ? WAIT_RDY : OFF;

    osc_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          rdy_s;
    logic          req_any;
    logic          fail_set;
    logic          en_nxt;
    logic          rdy_nxt;

    rcc_sync_cell #(
        .STAGES(SYNC_STAGES)
    ) u_rdy_sync (
        .i_clk(i_clk),
        .rst  (rst),
        .d    (osc_rdy_raw),
        .q    (rdy_s)
    );

    // A latched failure masks every request until software clears it.
    assign req_any = ~osc_fail &
                     (sw_osc_on | ((|per_ker_clk_req) & (~stop_mode | ker_on_in_stop)));

    always_comb begin
        state_nxt = state;
        fail_set  = 1'b0;
        case (state)
            OFF: begin
                if (req_any) state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!req_any) begin
                    state_nxt = STOPPING;
                end else if (rdy_s) begin
                    state_nxt = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail_set  = 1'b1;
                    state_nxt = STOPPING;
                end
            end
            STABILIZE: begin
                if (!rdy_s) begin
                    fail_set  = 1'b1;
                    state_nxt = STOPPING;
                end else if (!req_any) begin
                    state_nxt = STOPPING;
                end else if (cnt == STARTUP_LAST) begin
                    state_nxt = ON;
                end
            end
            ON: begin
                if (!rdy_s) begin
                    fail_set  = 1'b1;
                    state_nxt = STOPPING;
                end else if (!req_any) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (req_any) begin
                    state_nxt = ON;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (!rdy_s) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
        en_nxt  = state_nxt inside {WAIT_RDY, STABILIZE, ON, HOLD};
        rdy_nxt = state_nxt inside {ON, HOLD};
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_STATE;
            cnt         <= '0;
            osc_en      <= RESET_ON;
            osc_rdy     <= 1'b0;
            ker_clk_ack <= '0;
            osc_fail    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state) ? '0 : ((cnt == '1) ? cnt : cnt + CW'(1));
            osc_en  <= en_nxt;
            osc_rdy <= rdy_nxt;
            // Acks lag osc_rdy on the way up but drop together with it.
            ker_clk_ack <= per_ker_clk_req & {REQ_NUM{osc_rdy & rdy_nxt}};
            osc_fail    <= fail_set | (osc_fail & ~fail_clr);
        end
    end

endmodule

// File: tb/tb_ker_osc_req_responder.sv
// Directed bench for ker_osc_req_responder with default parameters, plus a
// RESET_ON=1 instance used only for the reset value of osc_en.
`timescale 1ns/1ps
module tb_ker_osc_req_responder;

    logic       i_clk = 1'b0;
    logic       rst;
    logic       sw_osc_on;
    logic [3:0] per_ker_clk_req;
    logic       stop_mode;
    logic       ker_on_in_stop;
    logic       osc_rdy_raw;
    logic       fail_clr;
    logic       osc_en, osc_rdy, osc_fail;
    logic [3:0] ker_clk_ack;
    logic       osc_en2, osc_rdy2, osc_fail2;
    logic [3:0] ker_clk_ack2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    ker_osc_req_responder dut (
        .i_clk(i_clk), .rst(rst), .sw_osc_on(sw_osc_on), .per_ker_clk_req(per_ker_clk_req),
        .stop_mode(stop_mode), .ker_on_in_stop(ker_on_in_stop), .osc_rdy_raw(osc_rdy_raw),
        .fail_clr(fail_clr), .osc_en(osc_en), .osc_rdy(osc_rdy), .ker_clk_ack(ker_clk_ack),
        .osc_fail(osc_fail)
    );

    ker_osc_req_responder #(.RESET_ON(1'b1)) dut_on (
        .i_clk(i_clk), .rst(rst), .sw_osc_on(sw_osc_on), .per_ker_clk_req(per_ker_clk_req),
        .stop_mode(stop_mode), .ker_on_in_stop(ker_on_in_stop), .osc_rdy_raw(osc_rdy_raw),
        .fail_clr(fail_clr), .osc_en(osc_en2), .osc_rdy(osc_rdy2), .ker_clk_ack(ker_clk_ack2),
        .osc_fail(osc_fail2)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic test_reset();
        tick(2);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL rst_osc_en got %b want 0", osc_en); else n_pass++;
        n_chk++; if (osc_rdy !== 1'b0) $display("FAIL rst_osc_rdy got %b want 0", osc_rdy); else n_pass++;
        n_chk++; if (ker_clk_ack !== 4'b0) $display("FAIL rst_ack got %b want 0000", ker_clk_ack); else n_pass++;
        n_chk++; if (osc_fail !== 1'b0) $display("FAIL rst_fail got %b want 0", osc_fail); else n_pass++;
        n_chk++; if (osc_en2 !== 1'b1) $display("FAIL rst_on_osc_en got %b want 1", osc_en2); else n_pass++;
        rst = 1'b0;
        tick(2);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL idle_osc_en got %b want 0", osc_en); else n_pass++;
    endtask

    task automatic test_startup();
        per_ker_clk_req = 4'b0010;
        tick(1);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL start_osc_en got %b want 1", osc_en); else n_pass++;
        tick(5);
        osc_rdy_raw = 1'b1;
        // 2 sync flops + 1 cycle into STABILIZE + 16 stabilisation cycles
        tick(18);
        n_chk++; if (osc_rdy !== 1'b0) $display("FAIL start_rdy_early got %b want 0", osc_rdy); else n_pass++;
        tick(1);
        n_chk++; if (osc_rdy !== 1'b1) $display("FAIL start_rdy got %b want 1", osc_rdy); else n_pass++;
        n_chk++; if (ker_clk_ack !== 4'b0000) $display("FAIL start_ack_early got %b want 0000", ker_clk_ack); else n_pass++;
        tick(1);
        n_chk++; if (ker_clk_ack !== 4'b0010) $display("FAIL start_ack got %b want 0010", ker_clk_ack); else n_pass++;
    endtask

    task automatic test_hold();
        int bad;
        per_ker_clk_req = 4'b0000;
        tick(1);
        n_chk++; if (ker_clk_ack !== 4'b0000) $display("FAIL hold_ack_drop got %b want 0000", ker_clk_ack); else n_pass++;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (osc_rdy !== 1'b1 || osc_en !== 1'b1) bad++;
            tick(1);
        end
        if (osc_rdy !== 1'b1 || osc_en !== 1'b1) bad++;
        per_ker_clk_req = 4'b0010;
        tick(1);
        if (osc_rdy !== 1'b1 || osc_en !== 1'b1) bad++;
        n_chk++; if (bad != 0) $display("FAIL hold_glitch got %0d low samples want 0", bad); else n_pass++;
        tick(1);
        n_chk++; if (ker_clk_ack !== 4'b0010) $display("FAIL hold_reack got %b want 0010", ker_clk_ack); else n_pass++;
        per_ker_clk_req = 4'b0000;
        tick(8);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL hold_en_kept got %b want 1", osc_en); else n_pass++;
        tick(1);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL hold_en_drop got %b want 0", osc_en); else n_pass++;
        n_chk++; if (osc_rdy !== 1'b0) $display("FAIL hold_rdy_drop got %b want 0", osc_rdy); else n_pass++;
        per_ker_clk_req = 4'b0010;
        tick(3);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL stopping_restart got %b want 0", osc_en); else n_pass++;
        osc_rdy_raw = 1'b0;
        tick(3);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL off_entry_en got %b want 0", osc_en); else n_pass++;
        tick(1);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL off_restart_en got %b want 1", osc_en); else n_pass++;
        per_ker_clk_req = 4'b0000;
        tick(3);
    endtask

    task automatic test_timeout();
        per_ker_clk_req = 4'b0010;
        tick(1);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL to_en got %b want 1", osc_en); else n_pass++;
        tick(1023);
        n_chk++; if (osc_fail !== 1'b0 || osc_en !== 1'b1)
            $display("FAIL to_early got fail=%b en=%b want fail=0 en=1", osc_fail, osc_en); else n_pass++;
        tick(1);
        n_chk++; if (osc_fail !== 1'b1 || osc_en !== 1'b0)
            $display("FAIL to_fail got fail=%b en=%b want fail=1 en=0", osc_fail, osc_en); else n_pass++;
        tick(5);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL to_req_ignored got %b want 0", osc_en); else n_pass++;
        fail_clr = 1'b1;
        tick(1);
        fail_clr = 1'b0;
        n_chk++; if (osc_fail !== 1'b0 || osc_en !== 1'b0)
            $display("FAIL to_clr got fail=%b en=%b want fail=0 en=0", osc_fail, osc_en); else n_pass++;
        tick(1);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL to_resume got %b want 1", osc_en); else n_pass++;
        per_ker_clk_req = 4'b0000;
        tick(3);
    endtask

    task automatic test_stop_mode();
        stop_mode = 1'b1;
        ker_on_in_stop = 1'b0;
        per_ker_clk_req = 4'b0001;
        tick(4);
        n_chk++; if (osc_en !== 1'b0) $display("FAIL stop_blocked got %b want 0", osc_en); else n_pass++;
        ker_on_in_stop = 1'b1;
        tick(1);
        n_chk++; if (osc_en !== 1'b1) $display("FAIL stop_honoured got %b want 1", osc_en); else n_pass++;
        stop_mode = 1'b0;
        ker_on_in_stop = 1'b0;
        per_ker_clk_req = 4'b0000;
        tick(3);
    endtask

    task automatic test_rdy_loss();
        per_ker_clk_req = 4'b0100;
        tick(1);
        osc_rdy_raw = 1'b1;
        tick(19);
        n_chk++; if (osc_rdy !== 1'b1) $display("FAIL loss_on got %b want 1", osc_rdy); else n_pass++;
        tick(1);
        n_chk++; if (ker_clk_ack !== 4'b0100) $display("FAIL loss_ack_on got %b want 0100", ker_clk_ack); else n_pass++;
        osc_rdy_raw = 1'b0;
        tick(2);
        n_chk++; if (osc_rdy !== 1'b1) $display("FAIL loss_rdy_early got %b want 1", osc_rdy); else n_pass++;
        // clear pulse coincides with the fault: the set must win
        fail_clr = 1'b1;
        tick(1);
        fail_clr = 1'b0;
        n_chk++; if (osc_rdy !== 1'b0) $display("FAIL loss_rdy got %b want 0", osc_rdy); else n_pass++;
        n_chk++; if (ker_clk_ack !== 4'b0000) $display("FAIL loss_ack got %b want 0000", ker_clk_ack); else n_pass++;
        n_chk++; if (osc_fail !== 1'b1) $display("FAIL loss_fail_vs_clr got %b want 1", osc_fail); else n_pass++;
        n_chk++; if (osc_en !== 1'b0) $display("FAIL loss_en got %b want 0", osc_en); else n_pass++;
        per_ker_clk_req = 4'b0000;
        tick(2);
        fail_clr = 1'b1;
        tick(1);
        fail_clr = 1'b0;
        n_chk++; if (osc_fail !== 1'b0) $display("FAIL loss_clr got %b want 0", osc_fail); else n_pass++;
        tick(2);
    endtask

    task automatic test_reset_mid();
        per_ker_clk_req = 4'b1000;
        tick(1);
        osc_rdy_raw = 1'b1;
        tick(5);
        n_chk++; if (osc_en !== 1'b1 || osc_rdy !== 1'b0)
            $display("FAIL mid_stab got en=%b rdy=%b want en=1 rdy=0", osc_en, osc_rdy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (osc_en !== 1'b0) $display("FAIL mid_rst_en got %b want 0", osc_en); else n_pass++;
        n_chk++; if (osc_rdy !== 1'b0 || ker_clk_ack !== 4'b0 || osc_fail !== 1'b0)
            $display("FAIL mid_rst_outs got rdy=%b ack=%b fail=%b want 0/0000/0", osc_rdy, ker_clk_ack, osc_fail);
        else n_pass++;
        n_chk++; if (osc_en2 !== 1'b1) $display("FAIL mid_rst_on_en got %b want 1", osc_en2); else n_pass++;
        tick(1);
        per_ker_clk_req = 4'b0000;
        osc_rdy_raw = 1'b0;
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        sw_osc_on = 1'b0;
        per_ker_clk_req = 4'b0000;
        stop_mode = 1'b0;
        ker_on_in_stop = 1'b0;
        osc_rdy_raw = 1'b0;
        fail_clr = 1'b0;
        test_reset();
        test_startup();
        test_hold();
        test_timeout();
        test_stop_mode();
        test_rdy_loss();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
